// File: rtl/mem_stage_sram_pkg.sv
// Shared types and defaults for the MEM stage and its SRAM port.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_stage_sram_pkg;

    localparam int          WORD_WIDTH_DEF     = 32;
    localparam int          REG_FILE_DEPTH_DEF = 4;
    localparam int          SRAM_ADDR_W_DEF    = 16;
    localparam int          WAIT_CYCLES_DEF    = 2;
    localparam logic [31:0] DATA_MEM_BASE      = 32'h400;

    // Wide enough for the largest legal wait-state count (15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

    // True on the final wait-state cycle of an SRAM access.
    function automatic logic last_wait(input logic [CNT_W-1:0] cnt, input int wait_cycles);
        return cnt == CNT_W'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/mem_stage_sram_mem_wb.sv
// MEM/WB pipeline register with bubble insertion.
// Latency: 1 cycle from d-inputs to outputs.
// Backpressure: bubble_i wins over load_i; with neither asserted the register holds.
// Ports: clk/rst_n, bubble_i, load_i, *_i next values, *_o registered MEM/WB fields.
module mem_wb_reg #(
    parameter int WORD_WIDTH     = 32,
    parameter int REG_FILE_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      bubble_i,
    input  logic                      load_i,
    input  logic                      mem_read_i,
    input  logic                      wb_en_i,
    input  logic [REG_FILE_DEPTH-1:0] dst_i,
    input  logic [WORD_WIDTH-1:0]     alu_res_i,
    input  logic [WORD_WIDTH-1:0]     mem_data_i,
    output logic                      mem_read_o,
    output logic                      wb_en_o,
    output logic [REG_FILE_DEPTH-1:0] dst_o,
    output logic [WORD_WIDTH-1:0]     alu_res_o,
    output logic [WORD_WIDTH-1:0]     mem_data_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_o <= 1'b0;
            wb_en_o    <= 1'b0;
            dst_o      <= '0;
            alu_res_o  <= '0;
            mem_data_o <= '0;
        end else if (bubble_i) begin
            mem_read_o <= 1'b0;
            wb_en_o    <= 1'b0;
            dst_o      <= '0;
            alu_res_o  <= '0;
            mem_data_o <= '0;
        end else if (load_i) begin
            mem_read_o <= mem_read_i;
            wb_en_o    <= wb_en_i;
            dst_o      <= dst_i;
            alu_res_o  <= alu_res_i;
            mem_data_o <= mem_data_i;
        end
    end

endmodule

// File: rtl/mem_stage_sram.sv
// MEM stage: loads/stores against a fixed-wait-state word SRAM, feeds MEM/WB.
// Latency: 1 cycle for ALU ops; WAIT_CYCLES+2 cycles of stage occupancy for memory ops.
// Backpressure: freeze stalls upstream for WAIT_CYCLES+1 cycles per memory op; bubbles go to WB meanwhile.
// Ports: EX/MEM inputs (mem_read_en, mem_write_en, WB_en, dst, ALU_res, val_Rm), freeze,
//        SRAM port (sram_addr/wdata/rdata/we_n/oe_n), MEM/WB outputs (*_out, mem_out).
module mem_stage_sram
    import mem_stage_sram_pkg::*;
#(
    parameter int          WORD_WIDTH     = WORD_WIDTH_DEF,
    parameter int          REG_FILE_DEPTH = REG_FILE_DEPTH_DEF,
    parameter int          SRAM_ADDR_W    = SRAM_ADDR_W_DEF,
    parameter int          WAIT_CYCLES    = WAIT_CYCLES_DEF,
    parameter logic [31:0] BASE_ADDR      = DATA_MEM_BASE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_read_en,
    input  logic                      mem_write_en,
    input  logic                      WB_en,
    input  logic [REG_FILE_DEPTH-1:0] dst,
    input  logic [WORD_WIDTH-1:0]     ALU_res,
    input  logic [WORD_WIDTH-1:0]     val_Rm,
    output logic                      freeze,
    output logic [SRAM_ADDR_W-1:0]    sram_addr,
    output logic [WORD_WIDTH-1:0]     sram_wdata,
    input  logic [WORD_WIDTH-1:0]     sram_rdata,
    output logic                      sram_we_n,
    output logic                      sram_oe_n,
    output logic                      mem_read_out,
    output logic                      WB_en_out,
    output logic [REG_FILE_DEPTH-1:0] dst_out,
    output logic [WORD_WIDTH-1:0]     ALU_res_out,
    output logic [WORD_WIDTH-1:0]     mem_out
);

    mem_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [SRAM_ADDR_W-1:0]    addr_q, addr_d;
    logic [WORD_WIDTH-1:0]     wdata_q, wdata_d;
    logic [WORD_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      rd_q, rd_d;
    logic                      wr_q, wr_d;
    logic                      wb_en_q, wb_en_d;
    logic [REG_FILE_DEPTH-1:0] dst_q, dst_d;
    logic [WORD_WIDTH-1:0]     alu_q, alu_d;

    logic                      req;
    logic                      freeze_c;
    logic                      wb_mem_read;
    logic                      wb_en_n;
    logic [REG_FILE_DEPTH-1:0] wb_dst;
    logic [WORD_WIDTH-1:0]     wb_alu;
    logic [WORD_WIDTH-1:0]     wb_mem;

    // Byte address relative to the SRAM window, as a word index; wraps modulo SRAM size.
    logic [WORD_WIDTH-1:0]     word_idx;
    logic                      unused_idx_hi;
    assign word_idx      = (ALU_res - WORD_WIDTH'(BASE_ADDR)) >> 2;
    assign unused_idx_hi = ^word_idx[WORD_WIDTH-1:SRAM_ADDR_W];

    assign req = mem_read_en | mem_write_en;

    // Reset must drop freeze immediately even if a request is still presented.
    assign freeze = freeze_c & rst;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        wb_en_d     = wb_en_q;
        dst_d       = dst_q;
        alu_d       = alu_q;
        freeze_c    = 1'b0;
        sram_addr   = '0;
        sram_wdata  = '0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        wb_mem_read = mem_read_en;
        wb_en_n     = WB_en;
        wb_dst      = dst;
        wb_alu      = ALU_res;
        wb_mem      = '0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    freeze_c = 1'b1;
                    addr_d   = word_idx[SRAM_ADDR_W-1:0];
                    wdata_d  = val_Rm;
                    // A simultaneous read+write is executed as a store.
                    rd_d     = mem_read_en & ~mem_write_en;
                    wr_d     = mem_write_en;
                    wb_en_d  = WB_en;
                    dst_d    = dst;
                    alu_d    = ALU_res;
                    cnt_d    = '0;
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                freeze_c  = 1'b1;
                sram_addr = addr_q;
                if (wr_q) begin
                    sram_wdata = wdata_q;
                    sram_we_n  = 1'b0;
                end else begin
                    sram_oe_n = 1'b0;
                end
                cnt_d = cnt_q + 1'b1;
                if (last_wait(cnt_q, WAIT_CYCLES)) begin
                    if (rd_q) begin
                        rdata_d = sram_rdata;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                wb_mem_read = rd_q;
                wb_en_n     = wb_en_q;
                wb_dst      = dst_q;
                wb_alu      = alu_q;
                wb_mem      = rd_q ? rdata_q : '0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wb_en_q <= 1'b0;
            dst_q   <= '0;
            alu_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wb_en_q <= wb_en_d;
            dst_q   <= dst_d;
            alu_q   <= alu_d;
        end
    end

    mem_wb_reg #(
        .WORD_WIDTH     (WORD_WIDTH),
        .REG_FILE_DEPTH (REG_FILE_DEPTH)
    ) u_mem_wb (
        .clk        (clk),
        .rst_n      (rst),
        .bubble_i   (freeze),
        .load_i     (~freeze),
        .mem_read_i (wb_mem_read),
        .wb_en_i    (wb_en_n),
        .dst_i      (wb_dst),
        .alu_res_i  (wb_alu),
        .mem_data_i (wb_mem),
        .mem_read_o (mem_read_out),
        .wb_en_o    (WB_en_out),
        .dst_o      (dst_out),
        .alu_res_o  (ALU_res_out),
        .mem_data_o (mem_out)
    );

endmodule
